// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC/exception sequencer.
// Holds the state encoding, PCSource / cause / ALUOp / ALUSrcB codes,
// and the opcode and funct constants decoded by the FSM.
// Optional feature: RTE_EN adds the return-from-exception state and decode.
package pc_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_BRANCH   = 4'd3,
        ST_JUMP     = 4'd4,
        ST_EXEC_R   = 4'd5,
        ST_EXC_SAVE = 4'd6,
        ST_EXC_READ = 4'd7,
        ST_EXC_LOAD = 4'd8
`ifdef RTE_EN
        ,
        ST_RTE      = 4'd9
`endif
    } state_e;

    localparam logic [2:0] PC_SRC_ALU_RESULT = 3'd0;
    localparam logic [2:0] PC_SRC_ALU_OUT    = 3'd1;
    localparam logic [2:0] PC_SRC_JUMP       = 3'd2;
    localparam logic [2:0] PC_SRC_VECTOR     = 3'd3;
`ifdef RTE_EN
    localparam logic [2:0] PC_SRC_EPC        = 3'd4;
`endif

    localparam logic [1:0] CAUSE_INVALID  = 2'd0;
    localparam logic [1:0] CAUSE_OVERFLOW = 2'd1;
    localparam logic [1:0] CAUSE_DIV_ZERO = 2'd2;

    localparam logic [1:0] ALU_OP_ADD   = 2'd0;
    localparam logic [1:0] ALU_OP_SUB   = 2'd1;
    localparam logic [1:0] ALU_OP_FUNCT = 2'd2;

    localparam logic [1:0] ALU_B_REG       = 2'd0;
    localparam logic [1:0] ALU_B_FOUR      = 2'd1;
    localparam logic [1:0] ALU_B_SEXT_SHL2 = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
`ifdef RTE_EN
    localparam logic [5:0] OP_RTE   = 6'h10;
    localparam logic [5:0] FN_RTE   = 6'h13;
`endif

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_DIV = 6'h1A;

    // Last count of a 3-cycle wait (counts 0, 1, 2).
    localparam logic [1:0] WAIT_LAST = 2'd2;

endpackage

// File: rtl/wait_counter.sv
// Small wait counter used for multi-cycle memory accesses.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance the count
//   clr        : synchronous clear (wins over en)
//   done       : count has reached WAIT_LAST
// The count saturates at WAIT_LAST, so it never wraps inside one state.
module wait_counter
    import pc_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic done
);

    logic [1:0] count_q;
    logic [1:0] count_d;

    assign done = (count_q == WAIT_LAST);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 2'd0;
        end else if (en && !done) begin
            count_d = count_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle PC / exception sequencer (Moore FSM).
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   opcode, funct       : instruction fields from the IR
//   zero, overflow      : ALU flags for the current cycle
//   div_zero            : divider reports a zero divisor
//   WritePC, WriteEPC, AluOutCtrl, IRWrite, MemRead : enables
//   PCSource, cause_control, ALUSrcA, ALUSrcB, ALUOp : datapath selects
//   state_out           : current state encoding for debug
// Optional feature: define RTE_EN to enable return-from-exception
// (opcode 0x10 / funct 0x13); otherwise that opcode is invalid.
//
// state       | meaning
// ------------+--------------------------------------------------
// RESET       | idle after reset, all outputs low
// FETCH       | 3-cycle instruction read, PC+4 and IR load on last
// DECODE      | precompute branch target into AluOut, dispatch
// BRANCH      | compare A-B, take beq/bne target
// JUMP        | load jump address into PC
// EXEC_R      | R-type ALU op, check overflow / divide-by-zero
// EXC_SAVE    | EPC <= PC-4, cause latched on entry
// EXC_READ    | 3-cycle read of the exception vector byte
// EXC_LOAD    | PC <= vector
// RTE         | PC <= EPC (RTE_EN only)
module pc_sequencer
    import pc_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    input  logic       div_zero,
    output logic       WritePC,
    output logic       WriteEPC,
    output logic       AluOutCtrl,
    output logic       IRWrite,
    output logic       MemRead,
    output logic [2:0] PCSource,
    output logic [1:0] cause_control,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [3:0] state_out
);

    state_e     state_q, state_d;
    logic [1:0] cause_q, cause_d;
    logic       wait_en, wait_clr, wait_done;
    logic       div_fault, ovf_fault;

    assign state_out     = state_q;
    assign cause_control = cause_q;

    assign wait_en  = (state_q == ST_FETCH) || (state_q == ST_EXC_READ);
    assign wait_clr = (state_d != state_q);

    wait_counter u_wait (
        .clk   (clk),
        .rst_n (reset),
        .en    (wait_en),
        .clr   (wait_clr),
        .done  (wait_done)
    );

    // A divide that also overflows is reported as overflow: overflow wins
    // whenever it coincides with a qualifying fault.
    assign div_fault = div_zero && (funct == FN_DIV);
    assign ovf_fault = overflow &&
                       ((funct == FN_ADD) || (funct == FN_SUB) || div_fault);

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        WritePC    = 1'b0;
        WriteEPC   = 1'b0;
        AluOutCtrl = 1'b0;
        IRWrite    = 1'b0;
        MemRead    = 1'b0;
        PCSource   = PC_SRC_ALU_RESULT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = ALU_B_REG;
        ALUOp      = ALU_OP_ADD;

        case (state_q)
            ST_RESET: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = ALU_B_FOUR;
                if (wait_done) begin
                    WritePC  = 1'b1;
                    PCSource = PC_SRC_ALU_RESULT;
                    IRWrite  = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                AluOutCtrl = 1'b1;
                ALUSrcB    = ALU_B_SEXT_SHL2;
                case (opcode)
                    OP_RTYPE:              state_d = ST_EXEC_R;
                    OP_BEQ, OP_BNE:        state_d = ST_BRANCH;
                    OP_J:                  state_d = ST_JUMP;
                    OP_ADDI, OP_LW, OP_SW: state_d = ST_FETCH;
                    default: begin
                        state_d = ST_EXC_SAVE;
                        cause_d = CAUSE_INVALID;
`ifdef RTE_EN
                        if ((opcode == OP_RTE) && (funct == FN_RTE)) begin
                            state_d = ST_RTE;
                            cause_d = cause_q;
                        end
`endif
                    end
                endcase
            end
            ST_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ALU_B_REG;
                ALUOp   = ALU_OP_SUB;
                // opcode[0] distinguishes bne from beq.
                if (zero ^ opcode[0]) begin
                    WritePC  = 1'b1;
                    PCSource = PC_SRC_ALU_OUT;
                end
                state_d = ST_FETCH;
            end
            ST_JUMP: begin
                WritePC  = 1'b1;
                PCSource = PC_SRC_JUMP;
                state_d  = ST_FETCH;
            end
            ST_EXEC_R: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = ALU_B_REG;
                ALUOp      = ALU_OP_FUNCT;
                AluOutCtrl = 1'b1;
                if (ovf_fault) begin
                    state_d = ST_EXC_SAVE;
                    cause_d = CAUSE_OVERFLOW;
                end else if (div_fault) begin
                    state_d = ST_EXC_SAVE;
                    cause_d = CAUSE_DIV_ZERO;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXC_SAVE: begin
                ALUSrcB  = ALU_B_FOUR;
                ALUOp    = ALU_OP_SUB;
                WriteEPC = 1'b1;
                state_d  = ST_EXC_READ;
            end
            ST_EXC_READ: begin
                MemRead = 1'b1;
                if (wait_done) begin
                    state_d = ST_EXC_LOAD;
                end
            end
            ST_EXC_LOAD: begin
                WritePC  = 1'b1;
                PCSource = PC_SRC_VECTOR;
                state_d  = ST_FETCH;
            end
`ifdef RTE_EN
            ST_RTE: begin
                WritePC  = 1'b1;
                PCSource = PC_SRC_EPC;
                state_d  = ST_FETCH;
            end
`endif
            default: begin
                state_d = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET;
            cause_q <= CAUSE_INVALID;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

    localparam logic [3:0] S_RESET = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                           S_BRANCH = 4'd3, S_JUMP = 4'd4, S_EXEC_R = 4'd5,
                           S_EXC_SAVE = 4'd6, S_EXC_READ = 4'd7,
                           S_EXC_LOAD = 4'd8, S_RTE = 4'd9;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = 6'h08;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0, overflow = 1'b0, div_zero = 1'b0;
    logic       WritePC, WriteEPC, AluOutCtrl, IRWrite, MemRead;
    logic [2:0] PCSource;
    logic [1:0] cause_control;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp;
    logic [3:0] state_out;

    int checks = 0;
    int passed = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .overflow(overflow), .div_zero(div_zero),
        .WritePC(WritePC), .WriteEPC(WriteEPC), .AluOutCtrl(AluOutCtrl),
        .IRWrite(IRWrite), .MemRead(MemRead), .PCSource(PCSource),
        .cause_control(cause_control), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       ov;
        logic       dz;
        logic [3:0] st1;
        logic       wpc1;
        logic [2:0] src1;
        logic [3:0] st2;
        logic       exc;
        logic [1:0] cause;
    } vec_t;

    vec_t vecs[$];
    logic [1:0] cause_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_state(input logic [3:0] s, input string name);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (state_out == s) return;
        end
        checks++;
        $display("FAIL %s: timeout, state 0x%0h expected 0x%0h", name, state_out, s);
    endtask

    function automatic logic [18:0] all_outs();
        return {WritePC, WriteEPC, AluOutCtrl, IRWrite, MemRead, PCSource,
                cause_control, ALUSrcA, ALUSrcB, ALUOp, state_out};
    endfunction

    initial begin
        // opcode, funct, zero, ovf, dz, st1, wpc1, src1, st2, exc, cause
        vecs.push_back('{6'h04, 6'h00, 1'b1, 1'b0, 1'b0, S_BRANCH, 1'b1, 3'd1, S_FETCH, 1'b0, 2'd0});
        vecs.push_back('{6'h05, 6'h00, 1'b1, 1'b0, 1'b0, S_BRANCH, 1'b0, 3'd0, S_FETCH, 1'b0, 2'd0});
        vecs.push_back('{6'h05, 6'h00, 1'b0, 1'b0, 1'b0, S_BRANCH, 1'b1, 3'd1, S_FETCH, 1'b0, 2'd0});
        vecs.push_back('{6'h04, 6'h00, 1'b0, 1'b0, 1'b0, S_BRANCH, 1'b0, 3'd0, S_FETCH, 1'b0, 2'd0});
        vecs.push_back('{6'h02, 6'h00, 1'b0, 1'b0, 1'b0, S_JUMP,   1'b1, 3'd2, S_FETCH, 1'b0, 2'd0});
        vecs.push_back('{6'h08, 6'h00, 1'b0, 1'b0, 1'b0, S_FETCH,  1'b0, 3'd0, S_FETCH, 1'b0, 2'd0});
        vecs.push_back('{6'h23, 6'h00, 1'b0, 1'b0, 1'b0, S_FETCH,  1'b0, 3'd0, S_FETCH, 1'b0, 2'd0});
        vecs.push_back('{6'h2B, 6'h00, 1'b0, 1'b0, 1'b0, S_FETCH,  1'b0, 3'd0, S_FETCH, 1'b0, 2'd0});
        vecs.push_back('{6'h00, 6'h20, 1'b0, 1'b0, 1'b0, S_EXEC_R, 1'b0, 3'd0, S_FETCH, 1'b0, 2'd0});
        vecs.push_back('{6'h00, 6'h1A, 1'b0, 1'b1, 1'b1, S_EXEC_R, 1'b0, 3'd0, S_EXC_SAVE, 1'b1, 2'd1});
        vecs.push_back('{6'h00, 6'h1A, 1'b0, 1'b0, 1'b1, S_EXEC_R, 1'b0, 3'd0, S_EXC_SAVE, 1'b1, 2'd2});
        vecs.push_back('{6'h3F, 6'h00, 1'b0, 1'b0, 1'b0, S_EXC_SAVE, 1'b0, 3'd0, S_EXC_READ, 1'b1, 2'd0});
        vecs.push_back('{6'h00, 6'h22, 1'b0, 1'b1, 1'b0, S_EXEC_R, 1'b0, 3'd0, S_EXC_SAVE, 1'b1, 2'd1});
        vecs.push_back('{6'h00, 6'h1A, 1'b0, 1'b1, 1'b0, S_EXEC_R, 1'b0, 3'd0, S_FETCH, 1'b0, 2'd0});
        vecs.push_back('{6'h00, 6'h20, 1'b0, 1'b0, 1'b1, S_EXEC_R, 1'b0, 3'd0, S_FETCH, 1'b0, 2'd0});
        vecs.push_back('{6'h10, 6'h00, 1'b0, 1'b0, 1'b0, S_EXC_SAVE, 1'b0, 3'd0, S_EXC_READ, 1'b1, 2'd0});
        vecs.push_back('{6'h00, 6'h22, 1'b0, 1'b1, 1'b0, S_EXEC_R, 1'b0, 3'd0, S_EXC_SAVE, 1'b1, 2'd1});
`ifdef RTE_EN
        vecs.push_back('{6'h10, 6'h13, 1'b0, 1'b0, 1'b0, S_RTE, 1'b1, 3'd4, S_FETCH, 1'b0, 2'd0});
`else
        vecs.push_back('{6'h10, 6'h13, 1'b0, 1'b0, 1'b0, S_EXC_SAVE, 1'b0, 3'd0, S_EXC_READ, 1'b1, 2'd0});
`endif

        // Reset held: everything low.
        #12;
        chk("reset_outs", {13'd0, all_outs()}, 32'd0);

        // Release and walk the first fetch.
        @(negedge clk);
        reset = 1'b1;
        #1 chk("release_state", {28'd0, state_out}, {28'd0, S_RESET});
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("fetch%0d_state", c), {28'd0, state_out}, {28'd0, S_FETCH});
            chk($sformatf("fetch%0d_memread", c), {31'd0, MemRead}, 32'd1);
            chk($sformatf("fetch%0d_wpc_ir", c), {30'd0, WritePC, IRWrite},
                (c == 3) ? 32'd3 : 32'd0);
            chk($sformatf("fetch%0d_alu", c), {27'd0, ALUSrcA, ALUSrcB, ALUOp}, {27'd0, 1'b0, 2'd1, 2'd0});
        end
        chk("fetch3_pcsrc", {29'd0, PCSource}, 32'd0);
        @(negedge clk);
        chk("decode_state", {28'd0, state_out}, {28'd0, S_DECODE});
        chk("decode_ctrl", {26'd0, AluOutCtrl, ALUSrcA, ALUSrcB, ALUOp, MemRead},
            {26'd0, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0});

        // Table-driven instruction vectors.
        cause_exp = 2'd0;
        for (int i = 0; i < vecs.size(); i++) begin
            wait_state(S_FETCH, $sformatf("v%0d_to_fetch", i));
            opcode   = vecs[i].op;
            funct    = vecs[i].fn;
            zero     = vecs[i].z;
            overflow = vecs[i].ov;
            div_zero = vecs[i].dz;
            wait_state(S_DECODE, $sformatf("v%0d_to_decode", i));
            @(negedge clk);
            chk($sformatf("v%0d_st1", i), {28'd0, state_out}, {28'd0, vecs[i].st1});
            chk($sformatf("v%0d_wpc", i), {31'd0, WritePC}, {31'd0, vecs[i].wpc1});
            chk($sformatf("v%0d_pcsrc", i), {29'd0, PCSource}, {29'd0, vecs[i].src1});
            chk($sformatf("v%0d_aluout", i), {31'd0, AluOutCtrl}, {31'd0, (vecs[i].st1 == S_EXEC_R)});
            if (vecs[i].exc) cause_exp = vecs[i].cause;
            if (vecs[i].st1 == S_EXC_SAVE) begin
                chk($sformatf("v%0d_epc", i), {31'd0, WriteEPC}, 32'd1);
                chk($sformatf("v%0d_cause", i), {30'd0, cause_control}, {30'd0, cause_exp});
            end
            @(negedge clk);
            chk($sformatf("v%0d_st2", i), {28'd0, state_out}, {28'd0, vecs[i].st2});
            if (vecs[i].st2 == S_EXC_SAVE) begin
                chk($sformatf("v%0d_epc", i), {31'd0, WriteEPC}, 32'd1);
                chk($sformatf("v%0d_cause", i), {30'd0, cause_control}, {30'd0, cause_exp});
            end
            chk($sformatf("v%0d_cause_held", i), {30'd0, cause_control}, {30'd0, cause_exp});
        end

        // Full overflow exception trace.
        wait_state(S_FETCH, "exc_to_fetch");
        opcode = 6'h00; funct = 6'h20; overflow = 1'b1; div_zero = 1'b0;
        wait_state(S_EXC_SAVE, "exc_to_save");
        chk("exc_save_ctrl", {25'd0, WriteEPC, WritePC, AluOutCtrl, ALUSrcA, ALUSrcB, ALUOp},
            {25'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1});
        chk("exc_save_cause", {30'd0, cause_control}, 32'd1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("exc_read%0d", c), {27'd0, state_out, MemRead}, {27'd0, S_EXC_READ, 1'b1});
            chk($sformatf("exc_read%0d_nowr", c), {29'd0, WritePC, WriteEPC, AluOutCtrl}, 32'd0);
        end
        @(negedge clk);
        chk("exc_load", {24'd0, state_out, WritePC, PCSource}, {24'd0, S_EXC_LOAD, 1'b1, 3'd3});
        chk("exc_load_aluout", {31'd0, AluOutCtrl}, 32'd0);
        @(negedge clk);
        chk("exc_back_fetch", {28'd0, state_out}, {28'd0, S_FETCH});

        // Reset in the 2nd EXC_READ cycle.
        wait_state(S_EXC_READ, "rst_to_read");
        @(negedge clk);
        chk("rst_read2", {28'd0, state_out}, {28'd0, S_EXC_READ});
        reset = 1'b0;
        overflow = 1'b0;
        #1 chk("rst_mid_outs", {13'd0, all_outs()}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk($sformatf("rst_fetch%0d", c), {27'd0, state_out, WritePC}, {27'd0, S_FETCH, 1'b0});
            chk($sformatf("rst_fetch%0d_epc", c), {31'd0, WriteEPC}, 32'd0);
        end
        chk("rst_cause", {30'd0, cause_control}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
